// File: rtl/place_bcd2bin.sv
// Serial two-digit BCD to binary converter (reverse double-dabble, one bit per clock).
// Latency: 8 clocks from the accepting edge for valid digits, 1 clock for an invalid digit.
// Backpressure: start is ignored while busy=1 (not queued); a start in the DONE cycle is accepted.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, ten, one   conversion request and its two BCD digits (captured only at acceptance)
//   busy              conversion in progress
//   done              one-cycle pulse when place_bin/err are updated
//   err               last accepted request had a digit greater than 9
//   place_bin         binary result 0..99
module place_bcd2bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] place_bin
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] sr;        // {bcd tens, bcd ones, binary accumulator}
    logic [15:0] sr_next;
    logic [2:0]  cnt;
    logic        bad_digit;

    assign bad_digit = (ten > 4'd9) || (one > 4'd9);

    // One reverse double-dabble step: shift right, then pull 3 back out of any
    // BCD nibble that reached 8 (undoes the half-borrow of 10 into 16).
    // On the last step both nibbles are already zero, so no special case.
    always_comb begin
        sr_next = {1'b0, sr[15:1]};
        if (sr_next[15:12] >= 4'd8) begin
            sr_next[15:12] = sr_next[15:12] - 4'd3;
        end
        if (sr_next[11:8] >= 4'd8) begin
            sr_next[11:8] = sr_next[11:8] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= 16'h0000;
            cnt       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            place_bin <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE behaves exactly like IDLE for a new request, which is
                // what gives back-to-back conversions every 9 clocks.
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        if (bad_digit) begin
                            err       <= 1'b1;
                            place_bin <= 8'h00;
                            done      <= 1'b1;
                        end else begin
                            sr    <= {ten, one, 8'h00};
                            cnt   <= 3'd0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        place_bin <= sr_next[7:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_place_bcd2bin.sv
module tb_place_bcd2bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] ten;
    logic [3:0] one;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] place_bin;

    int ncmp  = 0;
    int nfail = 0;

    place_bcd2bin dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ten       (ten),
        .one       (one),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .place_bin (place_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic [7:0] bin;
        logic       e;
        int         dk;   // sample index (0 = just after accepting edge) where done is seen
        int         bc;   // number of samples with busy=1
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Called and returns at a negedge. Issues one start, then samples each
    // negedge until done (bounded), then one more sample to confirm the pulse width.
    task automatic run(input logic [3:0] t, input logic [3:0] o,
                       output int dk, output int bc,
                       output logic [7:0] pb, output logic e, output logic done_after);
        ten = t; one = o; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dk = -1; bc = 0; pb = 8'hFF; e = 1'bx; done_after = 1'bx;
        for (int k = 0; k < 20; k++) begin
            if (busy) bc++;
            if (done) begin
                dk = k; pb = place_bin; e = err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    int         dk, bc, d1, d2, npulse;
    logic [7:0] pb, v1, v2, vb;
    logic       e, da, saw_done;

    initial begin
        vecs[0] = '{4'd5, 4'd9, 8'd59, 1'b0, 8, 8};
        vecs[1] = '{4'd0, 4'd0, 8'd0,  1'b0, 8, 8};
        vecs[2] = '{4'd9, 4'd9, 8'd99, 1'b0, 8, 8};
        vecs[3] = '{4'hA, 4'd3, 8'd0,  1'b1, 0, 0};
        vecs[4] = '{4'd2, 4'hF, 8'd0,  1'b1, 0, 0};
        vecs[5] = '{4'd1, 4'd2, 8'd12, 1'b0, 8, 8};
        vecs[6] = '{4'd8, 4'd0, 8'd80, 1'b0, 8, 8};
        vecs[7] = '{4'd0, 4'd9, 8'd9,  1'b0, 8, 8};
        vecs[8] = '{4'hF, 4'hF, 8'd0,  1'b1, 0, 0};
        vecs[9] = '{4'd3, 4'd8, 8'd38, 1'b0, 8, 8};

        // Reset with start asserted: reset must win.
        rst = 1'b1; start = 1'b1; ten = 4'd5; one = 4'd9;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_place_bin", place_bin, 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            run(vecs[i].t, vecs[i].o, dk, bc, pb, e, da);
            check($sformatf("vec%0d_done_at", i), dk, vecs[i].dk);
            check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].bc);
            check($sformatf("vec%0d_place_bin", i), pb, vecs[i].bin);
            check($sformatf("vec%0d_err", i), e, vecs[i].e);
            check($sformatf("vec%0d_done_width", i), da, 0);
        end

        // Full-range sweep.
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                run(4'(t), 4'(o), dk, bc, pb, e, da);
                check($sformatf("sweep_%0d%0d", t, o), pb, 10 * t + o);
                if (dk != 8 || e !== 1'b0) check($sformatf("sweep_%0d%0d_timing", t, o), dk, 8);
            end
        end

        // Input changes and start pulses while busy.
        ten = 4'd4; one = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        npulse = 0; vb = 8'hFF;
        for (int k = 0; k < 25; k++) begin
            if (k == 2) begin ten = 4'd9; one = 4'd9; start = 1'b1; end
            if (k == 3) start = 1'b0;
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            if (done) begin npulse++; vb = place_bin; end
            @(negedge clk);
        end
        check("busy_ignore_pulses", npulse, 1);
        check("busy_ignore_place_bin", vb, 47);

        // Back-to-back with start held.
        ten = 4'd2; one = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ten = 4'd5; one = 4'd8;
        d1 = -1; d2 = -1; v1 = 8'hFF; v2 = 8'hFF;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; v1 = place_bin;
                end else if (d2 < 0) begin
                    d2 = k; v2 = place_bin; start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_first", v1, 23);
        check("b2b_second", v2, 58);
        check("b2b_spacing", d2 - d1, 9);

        // Reset in the middle of a conversion.
        ten = 4'd7; one = 4'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_place_bin", place_bin, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_done", saw_done, 0);
        run(4'd7, 4'd1, dk, bc, pb, e, da);
        check("midrst_after_place_bin", pb, 71);
        check("midrst_after_err", e, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
